mips_ex_alu_unit: RTL and testbench
===================================

Name: mips_ex_alu_unit

Overview:
- Execute-stage arithmetic block for the 5-stage MIPS pipeline.
- Combines three functions:
  - ALU control decode: opcode + funct → 3-bit operation.
  - 32-bit ALU: combinational result plus a registered copy.
  - ID-stage branch-operand forwarding selector for BEQ/BNE.
- Sits between the ID/EX pipeline register, the forwarding muxes and the EX/MEM register.

Parameters:
- DATA_W, 32, ALU operand/result width.
- REG_AW, 5, register-specifier width.

Ports:
- clock  in  1  pipeline clock, rising-edge active
- reset  in  1  asynchronous, active-high; clears all registered outputs
- idex_op  in  6  opcode of instruction in EX
- idex_funct  in  6  funct field of instruction in EX
- op_a  in  DATA_W  forwarded operand A
- op_b  in  DATA_W  forwarded operand B
- ifid_op  in  6  opcode of instruction in ID
- ifid_rs  in  REG_AW  rs of instruction in ID
- ifid_rt  in  REG_AW  rt of instruction in ID
- exmem_dest  in  REG_AW  destination register written by the EX/MEM instruction
- memwb_dest  in  REG_AW  destination register written by the MEM/WB instruction
- alu_ctrl  out  3  decoded ALU operation
- alu_result  out  DATA_W  combinational ALU result
- alu_result_q  out  DATA_W  alu_result registered on clock
- zero  out  1  alu_result == 0 (combinational)
- overflow  out  1  signed overflow of ADD/SUB (see Optional Feature)
- br_fwd_a  out  2  branch operand A source select
- br_fwd_b  out  2  branch operand B source select

Behaviour:
- ALU control decode is combinational:
  - idex_op=000000 (R-type), by funct:
    - 0x20 ADD → 010
    - 0x22 SUB → 110
    - 0x24 AND → 000
    - 0x25 OR → 001
    - 0x26 XOR → 011
    - 0x27 NOR → 100
    - 0x2A SLT → 111
    - any other funct (incl. JR 0x08, nop) → 010
  - LW 100011, SW 101011, ADDI 001000 → 010 (address/immediate add).
  - BEQ 000100, BNE 000101 → 110.
  - ANDI 001100 → 000; ORI 001101 → 001.
  - All other opcodes (J, JAL, ...) → 010.
- ALU operations are combinational on op_a/op_b:
  - 000 AND; 001 OR; 010 ADD; 011 XOR; 100 NOR; 110 SUB.
  - 111 SLT: signed compare, result 1 if op_a < op_b, else 0.
  - 101 passes op_b.
  - ADD/SUB wrap modulo 2^32.
- zero reflects alu_result.
- alu_result_q:
  - Loads alu_result on every rising clock edge.
  - Resets asynchronously to 0; reset overrides the edge.
  - Latency 1 cycle.
- Branch forwarding is combinational and active only when ifid_op is BEQ or BNE; otherwise both selects are 00.
  - br_fwd_a = 01 if exmem_dest != 0 and exmem_dest == ifid_rs.
  - Else br_fwd_a = 10 if memwb_dest != 0 and memwb_dest == ifid_rs.
  - Else br_fwd_a = 00 (register file value).
  - br_fwd_b uses the same rules against ifid_rt.
  - EX/MEM has priority when both stages match.
  - Register $0 is never forwarded.
  - Selector 11 is never produced.
- No handshake; all combinational outputs are valid the same cycle; only alu_result_q is stateful.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - ADD: overflow=1 when op_a and op_b have the same sign and the result sign differs.
  - SUB: overflow=1 when op_a and op_b have differing signs and the result sign differs from op_a.
  - overflow=0 for all other operations.
  - Purely combinational flag; result still wraps.
- Not defined: overflow is tied to 0.

Test Plan:
- R-type ADD, funct 0x20, op_a=5, op_b=7 → alu_ctrl=010, alu_result=12, zero=0; alu_result_q=12 after the next rising edge.
- SUB, funct 0x22, 9-9 → result 0, zero=1.
- SLT, op_a=0xFFFFFFFF, op_b=1 → result 1.
- LW opcode → alu_ctrl=010; BEQ opcode → 110; J opcode → 010.
- Assert reset while alu_result_q=12 → alu_result_q=0 immediately without a clock edge; it loads again after reset is released.
- BEQ in ID, rs=3, rt=4, exmem_dest=3, memwb_dest=4 → br_fwd_a=01, br_fwd_b=10.
  - Same with exmem_dest=memwb_dest=3 → br_fwd_a=01.
  - rs=0, exmem_dest=0 → br_fwd_a=00.
  - ifid_op=ADD (R-type) → both selects 00.
- With ALU_OVERFLOW_EN defined: ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1.
- With ALU_OVERFLOW_EN undefined: the same ADD → overflow=0.

Source files
------------

// File: rtl/mips_ex_alu_unit.sv
// EX-stage ALU for the 5-stage MIPS pipeline: ALU control decode, 32-bit ALU with a registered
// result copy, and ID-stage BEQ/BNE operand forwarding. Optional macro: ALU_OVERFLOW_EN.
module mips_ex_alu_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        idex_op,
  input  logic [5:0]        idex_funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [5:0]        ifid_op,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic [REG_AW-1:0] exmem_dest,
  input  logic [REG_AW-1:0] memwb_dest,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_result_q,
  output logic              zero,
  output logic              overflow,
  output logic [1:0]        br_fwd_a,
  output logic [1:0]        br_fwd_b
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [2:0] CtrlAnd  = 3'b000;
  localparam logic [2:0] CtrlOr   = 3'b001;
  localparam logic [2:0] CtrlAdd  = 3'b010;
  localparam logic [2:0] CtrlXor  = 3'b011;
  localparam logic [2:0] CtrlNor  = 3'b100;
  localparam logic [2:0] CtrlPass = 3'b101;
  localparam logic [2:0] CtrlSub  = 3'b110;
  localparam logic [2:0] CtrlSlt  = 3'b111;

  always_comb begin
    alu_ctrl = CtrlAdd;
    case (idex_op)
      OpRtype: begin
        case (idex_funct)
          6'h20:   alu_ctrl = CtrlAdd;
          6'h22:   alu_ctrl = CtrlSub;
          6'h24:   alu_ctrl = CtrlAnd;
          6'h25:   alu_ctrl = CtrlOr;
          6'h26:   alu_ctrl = CtrlXor;
          6'h27:   alu_ctrl = CtrlNor;
          6'h2A:   alu_ctrl = CtrlSlt;
          default: alu_ctrl = CtrlAdd;
        endcase
      end
      OpLw, OpSw, OpAddi: alu_ctrl = CtrlAdd;
      OpBeq, OpBne:       alu_ctrl = CtrlSub;
      OpAndi:             alu_ctrl = CtrlAnd;
      OpOri:              alu_ctrl = CtrlOr;
      default:            alu_ctrl = CtrlAdd;
    endcase
  end

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              slt;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign slt  = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      CtrlAnd:  alu_result = op_a & op_b;
      CtrlOr:   alu_result = op_a | op_b;
      CtrlAdd:  alu_result = sum;
      CtrlXor:  alu_result = op_a ^ op_b;
      CtrlNor:  alu_result = ~(op_a | op_b);
      CtrlPass: alu_result = op_b;
      CtrlSub:  alu_result = diff;
      CtrlSlt:  alu_result = {{(DATA_W-1){1'b0}}, slt};
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    overflow = 1'b0;
    if (alu_ctrl == CtrlAdd) begin
      overflow = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
    end else if (alu_ctrl == CtrlSub) begin
      overflow = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
    end
  end
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_result_q <= '0;
    end else begin
      alu_result_q <= alu_result;
    end
  end

  // Register $0 is hardwired zero, so it is never a forwarding source; EX/MEM wins over MEM/WB.
  logic is_branch;
  assign is_branch = (ifid_op == OpBeq) || (ifid_op == OpBne);

  always_comb begin
    br_fwd_a = 2'b00;
    br_fwd_b = 2'b00;
    if (is_branch) begin
      if (exmem_dest != '0 && exmem_dest == ifid_rs) begin
        br_fwd_a = 2'b01;
      end else if (memwb_dest != '0 && memwb_dest == ifid_rs) begin
        br_fwd_a = 2'b10;
      end
      if (exmem_dest != '0 && exmem_dest == ifid_rt) begin
        br_fwd_b = 2'b01;
      end else if (memwb_dest != '0 && memwb_dest == ifid_rt) begin
        br_fwd_b = 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_mips_ex_alu_unit.sv
// Directed self-checking bench for mips_ex_alu_unit; overflow expectations follow ALU_OVERFLOW_EN.
module tb_mips_ex_alu_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  idex_op, idex_funct, ifid_op;
  logic [31:0] op_a, op_b;
  logic [4:0]  ifid_rs, ifid_rt, exmem_dest, memwb_dest;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result, alu_result_q;
  logic        zero, overflow;
  logic [1:0]  br_fwd_a, br_fwd_b;

  int checks = 0;
  int errors = 0;

`ifdef ALU_OVERFLOW_EN
  localparam logic OvfOn = 1'b1;
`else
  localparam logic OvfOn = 1'b0;
`endif

  mips_ex_alu_unit #(.DATA_W(32), .REG_AW(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .idex_op      (idex_op),
    .idex_funct   (idex_funct),
    .op_a         (op_a),
    .op_b         (op_b),
    .ifid_op      (ifid_op),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .exmem_dest   (exmem_dest),
    .memwb_dest   (memwb_dest),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_result_q (alu_result_q),
    .zero         (zero),
    .overflow     (overflow),
    .br_fwd_a     (br_fwd_a),
    .br_fwd_b     (br_fwd_b)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1;
    idex_op = 6'h00; idex_funct = 6'h20; op_a = 32'd0; op_b = 32'd0;
    ifid_op = 6'h00; ifid_rs = 5'd0; ifid_rt = 5'd0; exmem_dest = 5'd0; memwb_dest = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (alu_result_q !== 32'd0) begin
      errors++;
      $display("FAIL reset_q got %h want %h", alu_result_q, 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add_pipeline();
    @(negedge clock);
    idex_op = 6'h00; idex_funct = 6'h20; op_a = 32'd5; op_b = 32'd7;
    #1;
    checks++;
    if (alu_ctrl !== 3'b010 || alu_result !== 32'd12 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_comb got ctrl=%b res=%0d zero=%b want 010 12 0", alu_ctrl, alu_result, zero);
    end
    @(posedge clock); #1;
    checks++;
    if (alu_result_q !== 32'd12) begin
      errors++;
      $display("FAIL add_q got %0d want 12", alu_result_q);
    end
  endtask

  task automatic test_async_reset();
    // Reset lands mid-cycle, well away from any edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (alu_result_q !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got %h want 0", alu_result_q);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (alu_result_q !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold got %h want 0", alu_result_q);
    end
    @(posedge clock); #1;
    checks++;
    if (alu_result_q !== 32'd12) begin
      errors++;
      $display("FAIL reload_q got %0d want 12", alu_result_q);
    end
  endtask

  task automatic test_decode();
    logic [5:0] ops    [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08,
                               6'h04, 6'h05, 6'h0C, 6'h02};
    logic [5:0] fns    [12] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h08, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00};
    logic [2:0] expect_ctrl [12] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b010, 3'b010, 3'b010,
                                     3'b010, 3'b110, 3'b110, 3'b000, 3'b010};
    for (int i = 0; i < 12; i++) begin
      idex_op = ops[i]; idex_funct = fns[i];
      #1;
      checks++;
      if (alu_ctrl !== expect_ctrl[i]) begin
        errors++;
        $display("FAIL decode[%0d] op=%h fn=%h got %b want %b", i, ops[i], fns[i], alu_ctrl,
                 expect_ctrl[i]);
      end
    end
    idex_op = 6'h0D; idex_funct = 6'h00;
    #1;
    checks++;
    if (alu_ctrl !== 3'b001) begin
      errors++;
      $display("FAIL decode_ori got %b want 001", alu_ctrl);
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  fns [9] = '{6'h22, 6'h2A, 6'h2A, 6'h24, 6'h25, 6'h26, 6'h27, 6'h22, 6'h20};
    logic [31:0] av  [9] = '{32'd9, 32'hFFFF_FFFF, 32'd1, 32'hF0F0_00FF, 32'hF0F0_00FF,
                             32'hF0F0_00FF, 32'hF0F0_00FF, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] bv  [9] = '{32'd9, 32'd1, 32'hFFFF_FFFF, 32'h0FF0_0F0F, 32'h0FF0_0F0F,
                             32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'd5, 32'd2};
    logic [31:0] ev  [9] = '{32'd0, 32'd1, 32'd0, 32'h00F0_000F, 32'hFFF0_0FFF,
                             32'hFF00_0FF0, 32'h000F_F000, 32'hFFFF_FFFE, 32'd1};
    idex_op = 6'h00;
    for (int i = 0; i < 9; i++) begin
      idex_funct = fns[i]; op_a = av[i]; op_b = bv[i];
      #1;
      checks++;
      if (alu_result !== ev[i] || zero !== (ev[i] == 32'd0)) begin
        errors++;
        $display("FAIL alu[%0d] fn=%h got %h zero=%b want %h zero=%b", i, fns[i], alu_result,
                 zero, ev[i], (ev[i] == 32'd0));
      end
    end
  endtask

  task automatic test_overflow();
    idex_op = 6'h00; idex_funct = 6'h20; op_a = 32'h7FFF_FFFF; op_b = 32'd1;
    #1;
    checks++;
    if (alu_result !== 32'h8000_0000 || overflow !== OvfOn) begin
      errors++;
      $display("FAIL ovf_add got %h ovf=%b want 80000000 ovf=%b", alu_result, overflow, OvfOn);
    end
    idex_funct = 6'h22; op_a = 32'h8000_0000; op_b = 32'd1;
    #1;
    checks++;
    if (alu_result !== 32'h7FFF_FFFF || overflow !== OvfOn) begin
      errors++;
      $display("FAIL ovf_sub got %h ovf=%b want 7fffffff ovf=%b", alu_result, overflow, OvfOn);
    end
    idex_funct = 6'h20; op_a = 32'd5; op_b = 32'd7;
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_none got %b want 0", overflow);
    end
    idex_funct = 6'h24; op_a = 32'h7FFF_FFFF; op_b = 32'h8000_0001;
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_and got %b want 0", overflow);
    end
  endtask

  task automatic test_branch_fwd();
    logic [5:0] opv [7] = '{6'h04, 6'h04, 6'h04, 6'h00, 6'h05, 6'h05, 6'h04};
    logic [4:0] rsv [7] = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd7, 5'd1, 5'd2};
    logic [4:0] rtv [7] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd9, 5'd9, 5'd2};
    logic [4:0] exv [7] = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd9, 5'd0, 5'd2};
    logic [4:0] mwv [7] = '{5'd4, 5'd3, 5'd4, 5'd4, 5'd9, 5'd0, 5'd2};
    logic [1:0] ea  [7] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [1:0] eb  [7] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01};
    for (int i = 0; i < 7; i++) begin
      ifid_op = opv[i]; ifid_rs = rsv[i]; ifid_rt = rtv[i];
      exmem_dest = exv[i]; memwb_dest = mwv[i];
      #1;
      checks++;
      if (br_fwd_a !== ea[i] || br_fwd_b !== eb[i]) begin
        errors++;
        $display("FAIL brfwd[%0d] got a=%b b=%b want a=%b b=%b", i, br_fwd_a, br_fwd_b, ea[i],
                 eb[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    idex_op = 6'h00; idex_funct = 6'h20;
    @(negedge clock); op_a = 32'd100; op_b = 32'd1;
    @(negedge clock); op_a = 32'd200; op_b = 32'd2;
    #1;
    checks++;
    if (alu_result_q !== 32'd101) begin
      errors++;
      $display("FAIL b2b_first got %0d want 101", alu_result_q);
    end
    @(posedge clock); #1;
    checks++;
    if (alu_result_q !== 32'd202) begin
      errors++;
      $display("FAIL b2b_second got %0d want 202", alu_result_q);
    end
  endtask

  initial begin
    test_reset();
    test_add_pipeline();
    test_async_reset();
    test_decode();
    test_alu_ops();
    test_overflow();
    test_branch_fwd();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
